// File: rtl/rsz_pxl_forwarder.sv
// Resized-pixel forwarder: walks the block buffer's "executed" flags in raster
// order, flushes each executed block through one-hot X/Y masks and re-emits
// its pixel on a valid/ready stream with coordinates and end-of-frame marking.
module rsz_pxl_forwarder #(
  parameter int RSZ_W     = 4,
  parameter int RSZ_H     = 4,
  parameter int COLOR_NUM = 3,
  parameter int COLOR_W   = 8,
  localparam int XW = (RSZ_W > 1) ? $clog2(RSZ_W) : 1,
  localparam int YW = (RSZ_H > 1) ? $clog2(RSZ_H) : 1,
  localparam int DW = COLOR_NUM * COLOR_W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   SoftClr,
  input  logic [RSZ_W*RSZ_H-1:0] BlkIsExec,
  input  logic [DW-1:0]          FlushRszPxlData,
  output logic [RSZ_W-1:0]       FlushBlkXMsk,
  output logic [RSZ_H-1:0]       FlushBlkYMsk,
  output logic                   FlushVld,
  output logic [DW-1:0]          RszPxlData,
  output logic [XW-1:0]          RszPxlX,
  output logic [YW-1:0]          RszPxlY,
  output logic                   RszPxlLast,
  output logic                   RszPxlVld,
  input  logic                   RszPxlRdy,
  output logic                   FrmDone,
  output logic                   Busy
);

  localparam int NBLK = RSZ_W * RSZ_H;
  localparam int IW   = $clog2(NBLK);
  localparam logic [XW-1:0] X_LAST = XW'(RSZ_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(RSZ_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  // Output register stage (one cycle behind the flush strobe)
  logic [DW-1:0] data_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          last_p1;
  logic          vld_p1;
  logic          frm_done;

  logic [IW-1:0] blk_idx;
  logic          blk_exec;
  logic          cur_last;
  logic          space;
  logic          accept;
  logic          flush;

  // Cursor decode: one-hot masks, flat flag index and the flush decision.
  // SoftClr suppresses the strobe so the buffer never clears a flag whose
  // pixel is about to be thrown away.
  always_comb begin
    FlushBlkXMsk = RSZ_W'(1) << cur_x;
    FlushBlkYMsk = RSZ_H'(1) << cur_y;
    blk_idx      = IW'(cur_y) * IW'(RSZ_W) + IW'(cur_x);
    blk_exec     = BlkIsExec[blk_idx];
    cur_last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
    space        = ~vld_p1 | RszPxlRdy;
    accept       = vld_p1 & RszPxlRdy;
    flush        = (state == RUN) & blk_exec & space & ~SoftClr;
  end

  assign FlushVld   = flush;
  assign RszPxlData = data_p1;
  assign RszPxlX    = x_p1;
  assign RszPxlY    = y_p1;
  assign RszPxlLast = last_p1;
  assign RszPxlVld  = vld_p1;
  assign FrmDone    = frm_done;
  assign Busy       = (state != IDLE);

  // Frame FSM, raster cursor and registered output pixel
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      data_p1  <= '0;
      x_p1     <= '0;
      y_p1     <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      frm_done <= 1'b0;
    end else if (SoftClr) begin
      state    <= IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      vld_p1   <= 1'b0;
      frm_done <= 1'b0;
    end else begin
      frm_done <= 1'b0;
      case (state)
        IDLE:    if (Start) state <= RUN;
        RUN:     if (flush && cur_last) state <= DRAIN;
        DRAIN: begin
          if (accept && last_p1) begin
            state    <= IDLE;
            frm_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (flush) begin
        data_p1 <= FlushRszPxlData;
        x_p1    <= cur_x;
        y_p1    <= cur_y;
        last_p1 <= cur_last;
        vld_p1  <= 1'b1;
        if (cur_x == X_LAST) begin
          cur_x <= '0;
          cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
        end else begin
          cur_x <= cur_x + 1'b1;
        end
      end else if (accept) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule
